noc_link_tx: RTL and testbench

Output-side reader for a router input buffer. It pops flits from the local FIFO (registered read data, one-cycle read latency) and drives them onto the inter-router link. Credit-based flow control guarantees the downstream buffer never overflows. A packet-framing monitor counts completed packets and flags framing and credit protocol errors.

---
 rtl/noc_link_tx_if.sv | 23 ++
 rtl/noc_link_tx.sv | 109 ++++++++++
 tb/tb_noc_link_tx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_link_tx_if.sv
// Buffer-read and link-side signals of the router output reader.
// The master side is the transmitter and the slave side is the FIFO plus the link partner.
interface noc_link_tx_if #(
  parameter int NUM_BITS = 8
);
  logic                buf_empty;
  logic [NUM_BITS-1:0] buf_data;
  logic                buf_rd_en;
  logic                link_stop;
  logic                credit_in;
  logic                link_valid;
  logic [NUM_BITS-1:0] link_flit;

  modport master (
    input  buf_empty, buf_data, link_stop, credit_in,
    output buf_rd_en, link_valid, link_flit
  );

  modport slave (
    output buf_empty, buf_data, link_stop, credit_in,
    input  buf_rd_en, link_valid, link_flit
  );
endinterface

// File: rtl/noc_link_tx.sv
// Pops flits from the local FIFO onto the link under credit flow control,
// counts completed packets and flags framing and credit-overflow errors.
module noc_link_tx #(
  parameter int NUM_BITS = 8,
  parameter int CREDITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  noc_link_tx_if.master                lnk,
  output logic [$clog2(CREDITS):0]     credit_cnt,
  output logic [15:0]                  pkt_cnt,
  output logic                         proto_err,
  output logic                         tx_busy
);
  localparam int CW = $clog2(CREDITS) + 1;
  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDITS);
  localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  logic          issue;
  logic          pop_q;
  logic          credit_ovf;
  logic [CW-1:0] credit_nxt;
  logic [1:0]    ftype;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          pkt_done;
  logic          frame_err;

  // rst_n is active-high here; no pop may be requested while reset is held.
  assign issue = !rst_n && !lnk.buf_empty && (credit_cnt != '0) && !lnk.link_stop;

  assign lnk.buf_rd_en  = issue;
  assign lnk.link_valid = pop_q;
  assign lnk.link_flit  = pop_q ? lnk.buf_data : '0;
  assign ftype          = lnk.link_flit[NUM_BITS-1 -: 2];

  // A returned credit with no pop while already full has nowhere to go.
  assign credit_ovf = lnk.credit_in && !issue && (credit_cnt == CREDIT_FULL);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    credit_nxt = credit_cnt;
    if (issue && !lnk.credit_in)
      credit_nxt = credit_cnt - CREDIT_ONE;
    else if (!issue && lnk.credit_in && !credit_ovf)
      credit_nxt = credit_cnt + CREDIT_ONE;
  end

  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    frame_err = 1'b0;
    if (pop_q) begin
      if (state == S_IDLE) begin
        case (ftype)
          FT_HEAD:   state_nxt = S_IN_PKT;
          FT_SINGLE: pkt_done  = 1'b1;
          default:   frame_err = 1'b1;
        endcase
      end else begin
        case (ftype)
          FT_BODY: ;
          FT_TAIL: begin
            state_nxt = S_IDLE;
            pkt_done  = 1'b1;
          end
          // A second head restarts the packet; the abandoned one is not counted.
          FT_HEAD: frame_err = 1'b1;
          default: begin
            frame_err = 1'b1;
            state_nxt = S_IDLE;
            pkt_done  = 1'b1;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pop_q      <= 1'b0;
      credit_cnt <= CREDIT_FULL;
      pkt_cnt    <= '0;
      proto_err  <= 1'b0;
      state      <= S_IDLE;
    end else begin
      pop_q      <= issue;
      credit_cnt <= credit_nxt;
      state      <= state_nxt;
      if (pkt_done)
        pkt_cnt <= pkt_cnt + 16'd1;
      if (frame_err || credit_ovf)
        proto_err <= 1'b1;
    end
  end

  assign tx_busy = pop_q || (state == S_IN_PKT);

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed bench for noc_link_tx: a small FIFO model feeds the DUT and each
// scenario is compared against hand-computed link, credit and packet values.
module tb_noc_link_tx;
  logic        clk;
  logic        rst_n;
  logic [3:0]  credit_cnt;
  logic [15:0] pkt_cnt;
  logic        proto_err;
  logic        tx_busy;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  noc_link_tx_if #(.NUM_BITS(8)) lnk ();

  noc_link_tx #(.NUM_BITS(8), .CREDITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lnk        (lnk),
    .credit_cnt (credit_cnt),
    .pkt_cnt    (pkt_cnt),
    .proto_err  (proto_err),
    .tx_busy    (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model with one-cycle registered read data.
  assign lnk.buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (lnk.buf_rd_en) begin
      lnk.buf_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic credit_pulse();
    lnk.credit_in = 1'b1;
    @(posedge clk);
    #1;
    lnk.credit_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b1;
    flush         = 1'b1;
    lnk.credit_in = 1'b0;
    lnk.link_stop = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_flit [3];
    int pops;

    rst_n         = 1'b1;
    flush         = 1'b0;
    lnk.credit_in = 1'b0;
    lnk.link_stop = 1'b0;
    lnk.buf_data  = '0;

    // 1: reset values, then a three-flit packet
    do_reset();
    check("rst_link_valid", lnk.link_valid, 0);
    check("rst_link_flit", lnk.link_flit, 0);
    check("rst_credit_cnt", credit_cnt, 8);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_buf_rd_en", lnk.buf_rd_en, 0);

    exp_flit = '{8'h41, 8'h05, 8'h8A};
    push(8'h41); push(8'h05); push(8'h8A);
    #1;
    check("t1_rd_en_first", lnk.buf_rd_en, 1);
    check("t1_no_valid_yet", lnk.link_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t1_link_valid", lnk.link_valid, 1);
      check("t1_link_flit", lnk.link_flit, exp_flit[i]);
      check("t1_rd_en", lnk.buf_rd_en, (i < 2) ? 1 : 0);
    end
    check("t1_busy_mid", tx_busy, 1);
    wait_cycles(1);
    check("t1_valid_end", lnk.link_valid, 0);
    check("t1_credit_cnt", credit_cnt, 5);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_proto_err", proto_err, 0);
    check("t1_tx_busy", tx_busy, 0);

    // 2: credit exhaustion with 10 singles queued
    do_reset();
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (lnk.buf_rd_en) pops++;
      @(posedge clk);
      #1;
    end
    check("t2_pops", pops, 8);
    check("t2_rd_en_stalled", lnk.buf_rd_en, 0);
    check("t2_credit_zero", credit_cnt, 0);
    credit_pulse();
    #1;
    check("t2_rd_en_after_credit", lnk.buf_rd_en, 1);
    check("t2_credit_one", credit_cnt, 1);
    wait_cycles(1);
    check("t2_rd_en_after_pop", lnk.buf_rd_en, 0);
    check("t2_credit_back_zero", credit_cnt, 0);
    check("t2_flit9", lnk.link_flit, 8'hC8);
    wait_cycles(1);
    check("t2_pkt_cnt", pkt_cnt, 9);

    // 3: simultaneous pop and credit return, then overflow while idle
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
    wait_cycles(4);
    check("t3_credit_four", credit_cnt, 4);
    push(8'hC5);
    lnk.credit_in = 1'b1;
    #1;
    check("t3_rd_en_with_credit", lnk.buf_rd_en, 1);
    @(posedge clk);
    #1;
    lnk.credit_in = 1'b0;
    check("t3_credit_held", credit_cnt, 4);
    repeat (4) credit_pulse();
    check("t3_credit_full", credit_cnt, 8);
    check("t3_no_err_yet", proto_err, 0);
    credit_pulse();
    check("t3_credit_ovf_hold", credit_cnt, 8);
    check("t3_ovf_err", proto_err, 1);
    check("t3_pkt_cnt", pkt_cnt, 5);

    // 4: framing errors, reset between each
    do_reset();
    check("t4_err_cleared", proto_err, 0);
    push(8'h03);
    wait_cycles(3);
    check("t4a_err", proto_err, 1);
    check("t4a_pkt", pkt_cnt, 0);

    do_reset();
    push(8'h41); push(8'h42); push(8'h80);
    wait_cycles(5);
    check("t4b_err", proto_err, 1);
    check("t4b_pkt", pkt_cnt, 1);

    do_reset();
    push(8'hC7);
    wait_cycles(3);
    check("t4c_pkt", pkt_cnt, 1);
    check("t4c_err", proto_err, 0);

    // 5: link_stop while a flit is in flight
    do_reset();
    exp_flit = '{8'h05, 8'h06, 8'h8A};
    push(8'h41); push(8'h05); push(8'h06); push(8'h8A);
    #1;
    check("t5_rd_en_start", lnk.buf_rd_en, 1);
    @(posedge clk);
    #1;
    lnk.link_stop = 1'b1;
    #1;
    check("t5_stop_blocks_pop", lnk.buf_rd_en, 0);
    check("t5_inflight_valid", lnk.link_valid, 1);
    check("t5_inflight_flit", lnk.link_flit, 8'h41);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_stopped_valid", lnk.link_valid, 0);
      check("t5_stopped_rd_en", lnk.buf_rd_en, 0);
    end
    lnk.link_stop = 1'b0;
    #1;
    check("t5_resume_rd_en", lnk.buf_rd_en, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_order_valid", lnk.link_valid, 1);
      check("t5_order_flit", lnk.link_flit, exp_flit[i]);
    end
    wait_cycles(1);
    check("t5_pkt", pkt_cnt, 1);
    check("t5_err", proto_err, 0);

    // 6: reset asserted mid-packet with a flit in flight
    do_reset();
    push(8'h41); push(8'h05); push(8'h06);
    wait_cycles(2);
    check("t6_busy_before", tx_busy, 1);
    check("t6_valid_before", lnk.link_valid, 1);
    rst_n = 1'b1;
    flush = 1'b1;
    #1;
    check("t6_valid_async", lnk.link_valid, 0);
    check("t6_credit_async", credit_cnt, 8);
    check("t6_busy_async", tx_busy, 0);
    check("t6_rd_en_in_reset", lnk.buf_rd_en, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    push(8'h4F); push(8'h90);
    wait_cycles(4);
    check("t6_new_pkt", pkt_cnt, 1);
    check("t6_no_err", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
